// File: rtl/serial_add_ctrl_if.sv
// Requester <-> serial add/subtract controller handshake bundle.
// The requester (master) presents operands with start; the controller (slave) returns status and results.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    modport master (
        output start, sub, a, b,
        input  ready, busy, done, result, cout, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output ready, busy, done, result, cout, overflow
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell stepped over WIDTH cycles, LSB first,
// with a carry flop linking successive bit slices and a start/ready/done handshake.

module serial_add_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_add_ctrl_if.slave  bus
);
    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  sa_q, sa_d;
    logic [WIDTH-1:0]  sb_q, sb_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              c_q, c_d;
    logic              c_msb_q, c_msb_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic              fa_sum;
    logic              fa_co;
    logic              last_slice;

    serial_add_fa u_fa (
        .a  (sa_q[0]),
        .b  (sb_q[0]),
        .ci (c_q),
        .s  (fa_sum),
        .co (fa_co)
    );

    assign last_slice = (cnt_q == LAST_CNT);

    // NOTE: reset is synchronous, so it lives inside the clocked block and only acts on an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_slice) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block infers a latch.
        sa_d     = sa_q;
        sb_d     = sb_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        c_msb_d  = c_msb_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // Subtraction is a + ~b + 1: invert b here and seed the carry with sub.
                    sa_d     = bus.a;
                    sb_d     = bus.sub ? ~bus.b : bus.b;
                    c_d      = bus.sub;
                    cnt_d    = '0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                end
            end
            RUN: begin
                result_d            = result_q >> 1;
                result_d[WIDTH-1]   = fa_sum;
                sa_d                = sa_q >> 1;
                sb_d                = sb_q >> 1;
                c_d                 = fa_co;
                cnt_d               = cnt_q + 1'b1;
                if (last_slice) begin
                    c_msb_d = c_q;
                end
            end
            DONE: begin
                // Freeze the flags so they survive the carry reseed at the next accept.
                cout_d = c_q;
                ovf_d  = c_msb_q ^ c_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q <= '0;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            c_msb_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            c_msb_q  <= c_msb_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: operand shifters need no reset; they are always loaded at accept before being read.
    always_ff @(posedge clk) begin
        sa_q <= sa_d;
        sb_q <= sb_d;
    end

    always_comb begin
        bus.ready    = (state_q == IDLE);
        bus.busy     = (state_q == RUN);
        bus.done     = (state_q == DONE);
        bus.result   = result_q;
        bus.cout     = (state_q == DONE) ? c_q : cout_q;
        bus.overflow = (state_q == DONE) ? (c_msb_q ^ c_q) : ovf_q;
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: WIDTH=8 arithmetic, handshake, reset abort, and a WIDTH=1 instance.
module tb_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst8_n;
    logic rst1_n;
    bit   mon_en = 1'b0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst8_n), .bus(bus8));
    serial_add_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst1_n), .bus(bus1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ready/busy/done must be exactly one-hot on every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            check("onehot8", 32'($countones({bus8.ready, bus8.busy, bus8.done})), 1);
            check("onehot1", 32'($countones({bus1.ready, bus1.busy, bus1.done})), 1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One WIDTH=8 operation; done is expected after edge k+8 where k is the accept edge.
    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [7:0] er, input logic ec, input logic eo, input bit pulse);
        int lat;
        int nbusy;
        lat   = -1;
        nbusy = 0;
        for (int i = 0; i < 40 && !bus8.ready; i++) @(negedge clk);
        check({tag, " ready"}, 32'(bus8.ready), 1);
        bus8.start = 1'b1;
        bus8.a     = a;
        bus8.b     = b;
        bus8.sub   = s;
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.a     = ~a;
        bus8.b     = a ^ b;
        bus8.sub   = ~s;
        for (int j = 0; j < 20; j++) begin
            if (bus8.done) begin
                lat = j;
                break;
            end
            if (bus8.busy) nbusy++;
            if (pulse && (j == 2 || j == 5)) begin
                bus8.start = 1'b1;
                bus8.a     = 8'hAA;
                bus8.b     = 8'h55;
            end else begin
                bus8.start = 1'b0;
            end
            @(negedge clk);
        end
        bus8.start = 1'b0;
        check({tag, " latency"}, 32'(lat), 8);
        check({tag, " busy_cycles"}, 32'(nbusy), 8);
        check({tag, " result"}, 32'(bus8.result), 32'(er));
        check({tag, " cout"}, 32'(bus8.cout), 32'(ec));
        check({tag, " overflow"}, 32'(bus8.overflow), 32'(eo));
        @(negedge clk);
        check({tag, " done_one_cycle"}, 32'(bus8.done), 0);
        check({tag, " ready_after"}, 32'(bus8.ready), 1);
        check({tag, " result_held"}, 32'(bus8.result), 32'(er));
        check({tag, " cout_held"}, 32'(bus8.cout), 32'(ec));
        check({tag, " ovf_held"}, 32'(bus8.overflow), 32'(eo));
    endtask

    // One WIDTH=1 operation; done is expected after edge k+1.
    task automatic op1(input string tag, input logic a, input logic b, input logic s,
                       input logic er, input logic ec, input logic eo);
        int lat;
        lat = -1;
        for (int i = 0; i < 10 && !bus1.ready; i++) @(negedge clk);
        bus1.start = 1'b1;
        bus1.a     = a;
        bus1.b     = b;
        bus1.sub   = s;
        @(negedge clk);
        bus1.start = 1'b0;
        bus1.a     = ~a;
        bus1.b     = ~b;
        bus1.sub   = ~s;
        for (int j = 0; j < 10; j++) begin
            if (bus1.done) begin
                lat = j;
                break;
            end
            @(negedge clk);
        end
        check({tag, " latency"}, 32'(lat), 1);
        check({tag, " result"}, 32'(bus1.result), 32'(er));
        check({tag, " cout"}, 32'(bus1.cout), 32'(ec));
        check({tag, " overflow"}, 32'(bus1.overflow), 32'(eo));
    endtask

    // {a, b, sub, result, cout, overflow} for the 1-bit instance.
    localparam logic [5:0] W1_VEC [8] = '{
        6'b000_000, 6'b010_100, 6'b100_100, 6'b110_011,
        6'b001_010, 6'b011_101, 6'b101_110, 6'b111_010
    };

    initial begin
        int done_at[$];
        int ndone;
        logic [5:0] v;

        rst8_n     = 1'b0;
        rst1_n     = 1'b0;
        bus8.start = 1'b0; bus8.sub = 1'b0; bus8.a = '0; bus8.b = '0;
        bus1.start = 1'b0; bus1.sub = 1'b0; bus1.a = '0; bus1.b = '0;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        check("rst ready", 32'(bus8.ready), 1);
        check("rst busy", 32'(bus8.busy), 0);
        check("rst done", 32'(bus8.done), 0);
        check("rst result", 32'(bus8.result), 0);
        check("rst cout", 32'(bus8.cout), 0);
        check("rst overflow", 32'(bus8.overflow), 0);
        rst8_n = 1'b1;
        rst1_n = 1'b1;
        @(negedge clk);

        op8("add35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0);
        op8("addff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        op8("add7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        op8("sub10_20", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
        op8("sub80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
        op8("sub00_00", 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        op8("ignored_start", 8'h10, 8'h22, 1'b0, 8'h32, 1'b0, 1'b0, 1'b1);

        // Start held high: expect done at iterations 8, 18, 28, 38.
        bus8.start = 1'b1;
        bus8.a     = 8'h03;
        bus8.b     = 8'h04;
        bus8.sub   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus8.done) begin
                done_at.push_back(i);
                check("b2b result", 32'(bus8.result), 32'h07);
            end
        end
        bus8.start = 1'b0;
        check("b2b count", 32'(done_at.size()), 4);
        if (done_at.size() >= 4) begin
            check("b2b first", 32'(done_at[0]), 8);
            check("b2b gap1", 32'(done_at[1] - done_at[0]), 10);
            check("b2b gap3", 32'(done_at[3] - done_at[2]), 10);
        end

        // Reset during RUN cycle 4 aborts with no done pulse.
        for (int i = 0; i < 10 && !bus8.ready; i++) @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = 8'h55;
        bus8.b     = 8'h0F;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        rst8_n = 1'b0;
        @(negedge clk);
        check("abort ready", 32'(bus8.ready), 1);
        check("abort busy", 32'(bus8.busy), 0);
        check("abort done", 32'(bus8.done), 0);
        check("abort result", 32'(bus8.result), 0);
        check("abort cout", 32'(bus8.cout), 0);
        check("abort overflow", 32'(bus8.overflow), 0);
        rst8_n = 1'b1;
        ndone  = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus8.done) ndone++;
        end
        check("abort no_done", 32'(ndone), 0);
        op8("post_reset", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            v = W1_VEC[i];
            op1($sformatf("w1_%0d%0d%0d", v[5], v[4], v[3]), v[5], v[4], v[3], v[2], v[1], v[0]);
        end

        @(negedge clk);
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
